tp_tcam_wr_sched: RTL and testbench

Write scheduler and configuration sequencer for a DEPTH x WIDTH triple-port ternary CAM array built from flip-flop cells.
- Accepts entry write and invalidate requests from three independent requesters over valid/ready channels.
- Converts each (key, care) rule into per-bit stored value (St) and don't-care (M) bits.
- Drives the array's three write ports without same-address collisions.
- Sequences a full-array flush and keeps the per-entry valid vector that qualifies search hits.

---
 rtl/tcam_sched_pkg.sv | 37 +++
 rtl/tcam_req_hold.sv | 46 ++++
 rtl/tp_tcam_wr_sched.sv | 171 +++++++++++++++++
 tb/tb_tp_tcam_wr_sched.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/tcam_sched_pkg.sv
// rtl/tcam_sched_pkg.sv - shared types and rule encoding for the TCAM write scheduler
package tcam_sched_pkg;

  localparam int NPORT      = 3;
  localparam int TCAM_DEPTH = 64;
  localparam int TCAM_WIDTH = 32;
  localparam int TCAM_AW    = $clog2(TCAM_DEPTH);

  typedef struct packed {
    logic [TCAM_AW-1:0]    addr;
    logic [TCAM_WIDTH-1:0] st;
    logic [TCAM_WIDTH-1:0] m;
    logic                  inv;
  } wr_req_t;

  typedef struct packed {
    logic [TCAM_WIDTH-1:0] st;
    logic [TCAM_WIDTH-1:0] m;
  } cell_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } sched_state_t;

  // A compared bit stores its key value with M=0; a don't-care bit stores St=0, M=1.
  function automatic cell_t rule_to_cell(input logic [TCAM_WIDTH-1:0] key,
                                         input logic [TCAM_WIDTH-1:0] care);
    cell_t c;
    c.st = key & care;
    c.m  = ~care;
    return c;
  endfunction

endpackage

// File: rtl/tcam_req_hold.sv
// rtl/tcam_req_hold.sv - per-requester holding register with ready generation
module tcam_req_hold
  import tcam_sched_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_accept_en,
  input  logic                  i_valid,
  input  logic [TCAM_AW-1:0]    i_addr,
  input  logic [TCAM_WIDTH-1:0] i_key,
  input  logic [TCAM_WIDTH-1:0] i_care,
  input  logic                  i_inv,
  input  logic                  i_issue,
  output logic                  o_ready,
  output logic                  o_hold_v,
  output wr_req_t               o_hold
);

  logic    r_hold_v;
  wr_req_t r_hold;
  logic    w_load;
  cell_t   w_cell;

  // Ready depends only on local state and the issue decision, never on i_valid.
  assign o_ready  = i_accept_en & (~r_hold_v | i_issue);
  assign w_load   = i_valid & o_ready;
  assign w_cell   = rule_to_cell(i_key, i_care);
  assign o_hold_v = r_hold_v;
  assign o_hold   = r_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_v <= 1'b0;
      r_hold   <= '0;
    end else if (w_load) begin
      r_hold_v    <= 1'b1;
      r_hold.addr <= i_addr;
      r_hold.inv  <= i_inv;
      r_hold.st   <= i_inv ? '0 : w_cell.st;
      r_hold.m    <= i_inv ? '0 : w_cell.m;
    end else if (i_issue) begin
      r_hold_v <= 1'b0;
    end
  end

endmodule

// File: rtl/tp_tcam_wr_sched.sv
// rtl/tp_tcam_wr_sched.sv - triple-port TCAM write scheduler, flush sequencer and entry_valid keeper
module tp_tcam_wr_sched
  import tcam_sched_pkg::*;
#(
  parameter int DEPTH = TCAM_DEPTH,
  parameter int WIDTH = TCAM_WIDTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NPORT-1:0]       req_valid,
  output logic [NPORT-1:0]       req_ready,
  input  logic [NPORT*AW-1:0]    req_addr,
  input  logic [NPORT*WIDTH-1:0] req_key,
  input  logic [NPORT*WIDTH-1:0] req_care,
  input  logic [NPORT-1:0]       req_inv,
  input  logic                   flush_req,
  output logic                   flush_busy,
  output logic                   flush_done,
  output logic [NPORT-1:0]       arr_wen,
  output logic [NPORT*AW-1:0]    arr_waddr,
  output logic [NPORT*WIDTH-1:0] arr_wst,
  output logic [NPORT*WIDTH-1:0] arr_wm,
  output logic [DEPTH-1:0]       entry_valid
);

  localparam int FLUSH_CYC = (DEPTH + NPORT - 1) / NPORT;
  localparam int FCW       = $clog2(FLUSH_CYC + 1);
  localparam logic [FCW-1:0] FCNT_LAST = FCW'(FLUSH_CYC - 1);

  sched_state_t r_state, w_state_nxt;
  logic                   r_rst_done;
  logic [FCW-1:0]         r_fcnt;
  logic [NPORT-1:0]       r_wen;
  logic [NPORT*AW-1:0]    r_waddr;
  logic [NPORT*WIDTH-1:0] r_wst;
  logic [NPORT*WIDTH-1:0] r_wm;
  logic [DEPTH-1:0]       r_entry_valid;

  logic             w_accept_en;
  logic             w_flush_busy;
  logic             w_flush_done;
  logic [NPORT-1:0] w_hold_v;
  logic [NPORT-1:0] w_issue;
  logic [NPORT-1:0] w_addr_ok;
  logic [NPORT-1:0] w_flush_ok;
  logic [NPORT-1:0] w_ready;
  logic [AW+1:0]    w_flush_addr [NPORT];
  wr_req_t          w_hold [NPORT];

  for (genvar g = 0; g < NPORT; g++) begin : g_hold
    tcam_req_hold u_hold (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_accept_en (w_accept_en),
      .i_valid     (req_valid[g]),
      .i_addr      (req_addr[g*AW +: AW]),
      .i_key       (req_key[g*WIDTH +: WIDTH]),
      .i_care      (req_care[g*WIDTH +: WIDTH]),
      .i_inv       (req_inv[g]),
      .i_issue     (w_issue[g]),
      .o_ready     (w_ready[g]),
      .o_hold_v    (w_hold_v[g]),
      .o_hold      (w_hold[g])
    );
  end

  // A hold waits while any lower-index hold targets the same entry, so the higher port's data lands last.
  always_comb begin
    for (int i = 0; i < NPORT; i++) begin
      w_issue[i]   = w_hold_v[i];
      w_addr_ok[i] = ({1'b0, w_hold[i].addr} < (AW+1)'(DEPTH));
      for (int j = 0; j < i; j++) begin
        if (w_hold_v[j] && (w_hold[j].addr == w_hold[i].addr)) begin
          w_issue[i] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NPORT; i++) begin
      w_flush_addr[i] = (AW+2)'(r_fcnt) * (AW+2)'(NPORT) + (AW+2)'(i);
      w_flush_ok[i]   = (w_flush_addr[i] < (AW+2)'(DEPTH));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_rst_done <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_rst_done <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_accept_en  = 1'b0;
    w_flush_busy = 1'b1;
    w_flush_done = 1'b0;
    case (r_state)
      IDLE: begin
        w_flush_busy = 1'b0;
        w_accept_en  = r_rst_done;
        if (flush_req) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (w_hold_v == '0) w_state_nxt = FLUSH;
      end
      FLUSH: begin
        if (r_fcnt == FCNT_LAST) w_state_nxt = DONE;
      end
      DONE: begin
        w_flush_done = 1'b1;
        w_state_nxt  = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fcnt <= '0;
    end else if (r_state == DRAIN) begin
      r_fcnt <= '0;
    end else if ((r_state == FLUSH) && (r_fcnt != FCNT_LAST)) begin
      r_fcnt <= r_fcnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wen         <= '0;
      r_waddr       <= '0;
      r_wst         <= '0;
      r_wm          <= '0;
      r_entry_valid <= '0;
    end else begin
      r_wen <= '0;
      for (int i = 0; i < NPORT; i++) begin
        if (r_state == FLUSH) begin
          if (w_flush_ok[i]) begin
            r_wen[i]                          <= 1'b1;
            r_waddr[i*AW +: AW]               <= w_flush_addr[i][AW-1:0];
            r_wst[i*WIDTH +: WIDTH]           <= '0;
            r_wm[i*WIDTH +: WIDTH]            <= '0;
            r_entry_valid[w_flush_addr[i][AW-1:0]] <= 1'b0;
          end
        end else if (w_issue[i] && w_addr_ok[i]) begin
          r_wen[i]                       <= 1'b1;
          r_waddr[i*AW +: AW]            <= w_hold[i].addr;
          r_wst[i*WIDTH +: WIDTH]        <= w_hold[i].st;
          r_wm[i*WIDTH +: WIDTH]         <= w_hold[i].m;
          r_entry_valid[w_hold[i].addr]  <= ~w_hold[i].inv;
        end
      end
    end
  end

  assign req_ready   = w_ready;
  assign flush_busy  = w_flush_busy;
  assign flush_done  = w_flush_done;
  assign arr_wen     = r_wen;
  assign arr_waddr   = r_waddr;
  assign arr_wst     = r_wst;
  assign arr_wm      = r_wm;
  assign entry_valid = r_entry_valid;

endmodule

// File: tb/tb_tp_tcam_wr_sched.sv
// tb/tb_tp_tcam_wr_sched.sv - directed self-checking bench for the TCAM write scheduler
module tb_tp_tcam_wr_sched;

  localparam int DEPTH = 64;
  localparam int WIDTH = 32;
  localparam int AW    = 6;
  localparam int NP    = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NP-1:0]       req_valid;
  logic [NP-1:0]       req_ready;
  logic [NP*AW-1:0]    req_addr;
  logic [NP*WIDTH-1:0] req_key;
  logic [NP*WIDTH-1:0] req_care;
  logic [NP-1:0]       req_inv;
  logic              flush_req;
  logic              flush_busy;
  logic              flush_done;
  logic [NP-1:0]       arr_wen;
  logic [NP*AW-1:0]    arr_waddr;
  logic [NP*WIDTH-1:0] arr_wst;
  logic [NP*WIDTH-1:0] arr_wm;
  logic [DEPTH-1:0]    entry_valid;

  int checks   = 0;
  int failures = 0;

  tp_tcam_wr_sched #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_key     (req_key),
    .req_care    (req_care),
    .req_inv     (req_inv),
    .flush_req   (flush_req),
    .flush_busy  (flush_busy),
    .flush_done  (flush_done),
    .arr_wen     (arr_wen),
    .arr_waddr   (arr_waddr),
    .arr_wst     (arr_wst),
    .arr_wm      (arr_wm),
    .entry_valid (entry_valid)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic [AW-1:0] a, input logic [WIDTH-1:0] k,
                         input logic [WIDTH-1:0] c, input logic inv);
    req_valid[p]             = 1'b1;
    req_addr[p*AW +: AW]     = a;
    req_key[p*WIDTH +: WIDTH]  = k;
    req_care[p*WIDTH +: WIDTH] = c;
    req_inv[p]               = inv;
  endtask

  task automatic clr_req;
    req_valid = '0;
    req_inv   = '0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; flush_req = 1'b0; req_valid = '0; req_inv = '0;
    req_addr = '0; req_key = '0; req_care = '0;
    tick; tick;
    checks++; if (req_ready !== 3'b000) begin failures++; $display("FAIL reset_ready got=%b exp=000", req_ready); end
    checks++; if (arr_wen !== 3'b000) begin failures++; $display("FAIL reset_wen got=%b exp=000", arr_wen); end
    checks++; if (entry_valid !== '0) begin failures++; $display("FAIL reset_valid got=%h exp=0", entry_valid); end
    checks++; if (flush_busy !== 1'b0 || flush_done !== 1'b0) begin failures++; $display("FAIL reset_flush got=%b%b exp=00", flush_busy, flush_done); end
    checks++; if (arr_waddr !== '0 || arr_wst !== '0 || arr_wm !== '0) begin failures++; $display("FAIL reset_wdata got=%h/%h/%h exp=0", arr_waddr, arr_wst, arr_wm); end
    rst_n = 1'b1;
    tick;
    checks++; if (req_ready !== 3'b111) begin failures++; $display("FAIL reset_release_ready got=%b exp=111", req_ready); end
  endtask

  task automatic test_single_write;
    set_req(0, 6'd5, 32'hA5A5_0000, 32'hFFFF_0000, 1'b0);
    tick; clr_req;
    checks++; if (arr_wen !== 3'b000) begin failures++; $display("FAIL single_early_wen got=%b exp=000", arr_wen); end
    tick;
    checks++; if (arr_wen !== 3'b001) begin failures++; $display("FAIL single_wen got=%b exp=001", arr_wen); end
    checks++; if (arr_waddr[5:0] !== 6'd5) begin failures++; $display("FAIL single_waddr got=%0d exp=5", arr_waddr[5:0]); end
    checks++; if (arr_wst[31:0] !== 32'hA5A5_0000) begin failures++; $display("FAIL single_wst got=%h exp=a5a50000", arr_wst[31:0]); end
    checks++; if (arr_wm[31:0] !== 32'h0000_FFFF) begin failures++; $display("FAIL single_wm got=%h exp=0000ffff", arr_wm[31:0]); end
    checks++; if (entry_valid[5] !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", entry_valid[5]); end
    tick;
    checks++; if (arr_wen !== 3'b000) begin failures++; $display("FAIL single_wen_drop got=%b exp=000", arr_wen); end
  endtask

  task automatic test_parallel;
    set_req(0, 6'd1, 32'h11, 32'hFFFF_FFFF, 1'b0);
    set_req(1, 6'd2, 32'h22, 32'hFFFF_FFFF, 1'b0);
    set_req(2, 6'd3, 32'h33, 32'h0000_00F0, 1'b0);
    checks++; if (req_ready !== 3'b111) begin failures++; $display("FAIL par_ready0 got=%b exp=111", req_ready); end
    tick; clr_req;
    checks++; if (req_ready !== 3'b111) begin failures++; $display("FAIL par_ready1 got=%b exp=111", req_ready); end
    tick;
    checks++; if (arr_wen !== 3'b111) begin failures++; $display("FAIL par_wen got=%b exp=111", arr_wen); end
    checks++; if (arr_waddr !== {6'd3, 6'd2, 6'd1}) begin failures++; $display("FAIL par_waddr got=%h exp=%h", arr_waddr, {6'd3, 6'd2, 6'd1}); end
    checks++; if (arr_wst[95:64] !== 32'h30 || arr_wm[95:64] !== 32'hFFFF_FF0F) begin failures++; $display("FAIL par_cell2 got=%h/%h exp=30/ffffff0f", arr_wst[95:64], arr_wm[95:64]); end
    checks++; if (entry_valid[3:1] !== 3'b111) begin failures++; $display("FAIL par_valid got=%b exp=111", entry_valid[3:1]); end
    checks++; if (req_ready !== 3'b111) begin failures++; $display("FAIL par_ready2 got=%b exp=111", req_ready); end
  endtask

  task automatic test_conflict;
    set_req(0, 6'd7, 32'h1, 32'hFFFF_FFFF, 1'b0);
    set_req(2, 6'd7, 32'h2, 32'hFFFF_FFFF, 1'b0);
    tick; clr_req;
    checks++; if (req_ready !== 3'b011) begin failures++; $display("FAIL conf_ready got=%b exp=011", req_ready); end
    tick;
    checks++; if (arr_wen !== 3'b001 || arr_waddr[5:0] !== 6'd7 || arr_wst[31:0] !== 32'h1) begin failures++; $display("FAIL conf_first got=%b/%0d/%h exp=001/7/1", arr_wen, arr_waddr[5:0], arr_wst[31:0]); end
    tick;
    checks++; if (arr_wen !== 3'b100 || arr_waddr[17:12] !== 6'd7 || arr_wst[95:64] !== 32'h2) begin failures++; $display("FAIL conf_second got=%b/%0d/%h exp=100/7/2", arr_wen, arr_waddr[17:12], arr_wst[95:64]); end
    checks++; if (arr_wm[95:64] !== 32'h0 || entry_valid[7] !== 1'b1) begin failures++; $display("FAIL conf_final got=%h/%b exp=0/1", arr_wm[95:64], entry_valid[7]); end
    tick;
  endtask

  task automatic test_invalidate;
    set_req(0, 6'd9, 32'hFF, 32'hFFFF_FFFF, 1'b0);
    tick; clr_req; tick;
    checks++; if (entry_valid[9] !== 1'b1) begin failures++; $display("FAIL inv_pre_valid got=%b exp=1", entry_valid[9]); end
    set_req(1, 6'd9, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1);
    tick; clr_req; tick;
    checks++; if (arr_wen !== 3'b010 || arr_waddr[11:6] !== 6'd9) begin failures++; $display("FAIL inv_wen got=%b/%0d exp=010/9", arr_wen, arr_waddr[11:6]); end
    checks++; if (arr_wst[63:32] !== 32'h0 || arr_wm[63:32] !== 32'h0) begin failures++; $display("FAIL inv_cell got=%h/%h exp=0/0", arr_wst[63:32], arr_wm[63:32]); end
    checks++; if (entry_valid[9] !== 1'b0) begin failures++; $display("FAIL inv_valid got=%b exp=0", entry_valid[9]); end
  endtask

  task automatic test_back_to_back;
    set_req(0, 6'd40, 32'h40, 32'hFFFF_FFFF, 1'b0);
    tick;
    checks++; if (req_ready[0] !== 1'b1) begin failures++; $display("FAIL b2b_ready1 got=%b exp=1", req_ready[0]); end
    set_req(0, 6'd41, 32'h41, 32'hFFFF_FFFF, 1'b0);
    tick;
    checks++; if (arr_wen !== 3'b001 || arr_waddr[5:0] !== 6'd40 || arr_wst[31:0] !== 32'h40) begin failures++; $display("FAIL b2b_w40 got=%b/%0d/%h exp=001/40/40", arr_wen, arr_waddr[5:0], arr_wst[31:0]); end
    checks++; if (req_ready[0] !== 1'b1) begin failures++; $display("FAIL b2b_ready2 got=%b exp=1", req_ready[0]); end
    set_req(0, 6'd42, 32'h42, 32'hFFFF_FFFF, 1'b0);
    tick; clr_req;
    checks++; if (arr_wen !== 3'b001 || arr_waddr[5:0] !== 6'd41) begin failures++; $display("FAIL b2b_w41 got=%b/%0d exp=001/41", arr_wen, arr_waddr[5:0]); end
    tick;
    checks++; if (arr_wen !== 3'b001 || arr_waddr[5:0] !== 6'd42) begin failures++; $display("FAIL b2b_w42 got=%b/%0d exp=001/42", arr_wen, arr_waddr[5:0]); end
    tick;
    checks++; if (arr_wen !== 3'b000 || entry_valid[42:40] !== 3'b111) begin failures++; $display("FAIL b2b_end got=%b/%b exp=000/111", arr_wen, entry_valid[42:40]); end
  endtask

  task automatic test_flush;
    int nz, n111, dones;
    bit ready_bad, ended;
    logic [2:0]    wen_at_done;
    logic [AW-1:0] a0_at_done;
    nz = 0; n111 = 0; dones = 0; ready_bad = 0; ended = 0;
    wen_at_done = '0; a0_at_done = '0;
    set_req(0, 6'd10, 32'hA, 32'hFFFF_FFFF, 1'b0);
    set_req(1, 6'd11, 32'hB, 32'hFFFF_FFFF, 1'b0);
    flush_req = 1'b1;
    tick; flush_req = 1'b0; clr_req;
    checks++; if (flush_busy !== 1'b1 || req_ready !== 3'b000) begin failures++; $display("FAIL flush_drain got=%b/%b exp=1/000", flush_busy, req_ready); end
    tick;
    checks++; if (arr_wen !== 3'b011 || entry_valid[11:10] !== 2'b11) begin failures++; $display("FAIL flush_drain_wr got=%b/%b exp=011/11", arr_wen, entry_valid[11:10]); end
    for (int i = 0; i < 60 && !ended; i++) begin
      flush_req = (i == 4);
      tick;
      if (flush_busy && req_ready !== 3'b000) ready_bad = 1;
      if (arr_wen !== 3'b000) nz++;
      if (arr_wen === 3'b111) n111++;
      if (flush_done) begin dones++; wen_at_done = arr_wen; a0_at_done = arr_waddr[5:0]; end
      if (!flush_busy) ended = 1;
    end
    flush_req = 1'b0;
    checks++; if (!ended) begin failures++; $display("FAIL flush_timeout got=busy exp=idle"); end
    checks++; if (nz != 22 || n111 != 21) begin failures++; $display("FAIL flush_cycles got=%0d/%0d exp=22/21", nz, n111); end
    checks++; if (dones != 1) begin failures++; $display("FAIL flush_done_count got=%0d exp=1", dones); end
    checks++; if (wen_at_done !== 3'b001 || a0_at_done !== 6'd63) begin failures++; $display("FAIL flush_last got=%b/%0d exp=001/63", wen_at_done, a0_at_done); end
    checks++; if (entry_valid !== '0) begin failures++; $display("FAIL flush_valid got=%h exp=0", entry_valid); end
    checks++; if (ready_bad) begin failures++; $display("FAIL flush_ready_blocked got=open exp=blocked"); end
    checks++; if (req_ready !== 3'b111) begin failures++; $display("FAIL flush_ready_after got=%b exp=111", req_ready); end
    tick;
    checks++; if (flush_busy !== 1'b0) begin failures++; $display("FAIL flush_req_queued got=%b exp=0", flush_busy); end
  endtask

  task automatic test_reset_mid_flush;
    bit found;
    int dones;
    found = 0; dones = 0;
    set_req(0, 6'd50, 32'h5, 32'hFFFF_FFFF, 1'b0);
    tick; clr_req; tick;
    checks++; if (entry_valid[50] !== 1'b1) begin failures++; $display("FAIL rmf_pre_valid got=%b exp=1", entry_valid[50]); end
    flush_req = 1'b1;
    tick; flush_req = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      tick;
      if (arr_wen === 3'b111 && arr_waddr[5:0] === 6'd27) found = 1;
    end
    checks++; if (!found) begin failures++; $display("FAIL rmf_reach_k10 got=missing exp=waddr0_27"); end
    rst_n = 1'b0;
    #1;
    checks++; if (arr_wen !== 3'b000 || flush_busy !== 1'b0) begin failures++; $display("FAIL rmf_async got=%b/%b exp=000/0", arr_wen, flush_busy); end
    checks++; if (entry_valid !== '0) begin failures++; $display("FAIL rmf_valid got=%h exp=0", entry_valid); end
    tick;
    rst_n = 1'b1;
    tick;
    checks++; if (req_ready !== 3'b111 || flush_busy !== 1'b0) begin failures++; $display("FAIL rmf_idle got=%b/%b exp=111/0", req_ready, flush_busy); end
    for (int i = 0; i < 30; i++) begin
      tick;
      if (flush_done) dones++;
    end
    checks++; if (dones != 0) begin failures++; $display("FAIL rmf_no_done got=%0d exp=0", dones); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_parallel();
    test_conflict();
    test_invalidate();
    test_back_to_back();
    test_flush();
    test_reset_mid_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end

endmodule
